// File: rtl/mem_bus_responder.sv
// mem_bus_responder: KianV native memory bus endpoint backed by word-organised
// RAM with byte-strobe writes and a fixed number of wait states per access.
module mem_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            commit_c;
  logic [AW-1:0]   acc_idx_c;
  logic [31:0]     acc_wdata_c;
  logic [3:0]      acc_wstrb_c;

  // Word-offset bits and bits above the RAM index do not select storage.
  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // Commit strobe and access qualifiers; the IDLE path serves single-cycle latency.
  always_comb begin
    commit_c    = 1'b0;
    acc_idx_c   = idx_q;
    acc_wdata_c = wdata_q;
    acc_wstrb_c = wstrb_q;
    if (state == IDLE) begin
      acc_idx_c   = mem_addr[AW+1:2];
      acc_wdata_c = mem_wdata;
      acc_wstrb_c = mem_wstrb;
    end
    if (resetn) begin
      if (state == IDLE && mem_valid && LATENCY == 1) commit_c = 1'b1;
      if (state == WAIT && cnt <= CW'(1)) commit_c = 1'b1;
    end
  end

  // Request FSM with registered ready/busy/read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      busy      <= 1'b0;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
    end else begin
      mem_ready <= 1'b0;
      if (commit_c && acc_wstrb_c == 4'b0000) mem_rdata <= mem[acc_idx_c];
      case (state)
        IDLE: begin
          if (mem_valid) begin
            idx_q   <= mem_addr[AW+1:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            busy    <= 1'b1;
            if (LATENCY == 1) begin
              state     <= RESP;
              mem_ready <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (commit_c) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-strobed RAM write on the commit edge.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb_c[i]) mem[acc_idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (LATENCY 2, 1, 4) on a shared clock.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        busy  [3];

  int          pass_cnt = 0;
  int          total    = 0;
  logic [31:0] sb [$];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (valid[g]),
      .mem_addr  (addr[g]),
      .mem_wdata (wdata[g]),
      .mem_wstrb (wstrb[g]),
      .mem_ready (ready[g]),
      .mem_rdata (rdata[g]),
      .busy      (busy[g])
    );
  end

  // Drives one request and reports latency, captured read data and busy coverage.
  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output int lat, output logic [31:0] rd,
                      output logic bz);
    valid[k] = 1'b1; addr[k] = a; wdata[k] = wd; wstrb[k] = ws;
    lat = -1; rd = 32'h0; bz = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        wstrb[k] = 4'($urandom);
      end
      if (!busy[k]) bz = 1'b0;
      if (ready[k]) begin
        lat = n;
        rd  = rdata[k];
        break;
      end
    end
    valid[k] = 1'b0;
    wstrb[k] = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0; wstrb[i] = 4'h0; last_rd[i] = 32'h0;
    end
    resetn = 1'b0;
    valid[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h0; wstrb[0] = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (ready[0] !== 1'b0) $display("FAIL reset_ready got %b want 0", ready[0]); else pass_cnt++;
      total++; if (rdata[0] !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata[0]); else pass_cnt++;
      total++; if (busy[0] !== 1'b0) $display("FAIL reset_busy got %b want 0", busy[0]); else pass_cnt++;
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (busy[0] !== 1'b1) $display("FAIL reset_first_accept busy got %b want 1", busy[0]); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total++; if (ready[0] !== 1'b1) $display("FAIL reset_first_ready got %b want 1", ready[0]); else pass_cnt++;
    valid[0] = 1'b0; wstrb[0] = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic bz; logic [31:0] exp;
    sb.push_back(last_rd[0]);
    xact(0, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, bz);
    exp = sb.pop_front();
    total++; if (lat !== 2) $display("FAIL wr_latency got %0d want 2", lat); else pass_cnt++;
    total++; if (rd !== exp) $display("FAIL wr_rdata_hold got %h want %h", rd, exp); else pass_cnt++;
    total++; if (bz !== 1'b1) $display("FAIL wr_busy got %b want 1", bz); else pass_cnt++;
    sb.push_back(32'hDEADBEEF);
    xact(0, 32'h10, 32'h0, 4'h0, lat, rd, bz);
    exp = sb.pop_front();
    total++; if (lat !== 2) $display("FAIL rd_latency got %0d want 2", lat); else pass_cnt++;
    total++; if (rd !== exp) $display("FAIL rd_data got %h want %h", rd, exp); else pass_cnt++;
    last_rd[0] = exp;
  endtask

  task automatic test_strobes();
    int lat; logic [31:0] rd; logic bz; logic [31:0] exp;
    xact(0, 32'h20, 32'h11223344, 4'hF, lat, rd, bz);
    sb.push_back(last_rd[0]);
    xact(0, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, bz);
    exp = sb.pop_front();
    total++; if (rd !== exp) $display("FAIL strobe_wr_rdata_hold got %h want %h", rd, exp); else pass_cnt++;
    sb.push_back(32'h11BB33DD);
    xact(0, 32'h20, 32'h0, 4'h0, lat, rd, bz);
    exp = sb.pop_front();
    total++; if (rd !== exp) $display("FAIL strobe_merge got %h want %h", rd, exp); else pass_cnt++;
    last_rd[0] = exp;
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rd; logic bz; logic [31:0] exp;
    xact(0, 32'h0000_1004, 32'h5A5A5A5A, 4'hF, lat, rd, bz);
    sb.push_back(32'h5A5A5A5A);
    xact(0, 32'h0000_0004, 32'h0, 4'h0, lat, rd, bz);
    exp = sb.pop_front();
    total++; if (rd !== exp) $display("FAIL alias_rd4 got %h want %h", rd, exp); else pass_cnt++;
    sb.push_back(32'h5A5A5A5A);
    xact(0, 32'h0000_0007, 32'h0, 4'h0, lat, rd, bz);
    exp = sb.pop_front();
    total++; if (rd !== exp) $display("FAIL alias_rd7 got %h want %h", rd, exp); else pass_cnt++;
    total++; if (lat !== 2) $display("FAIL alias_latency got %0d want 2", lat); else pass_cnt++;
    last_rd[0] = exp;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic bz; logic [31:0] exp;
    int nready; int idx; int last_c;
    for (int i = 0; i < 4; i++) xact(1, 32'(4 * i), 32'hB0B0_0000 + 32'(i * 17), 4'hF, lat, rd, bz);
    total++; if (lat !== 1) $display("FAIL b2b_single_latency got %0d want 1", lat); else pass_cnt++;
    for (int i = 0; i < 4; i++) sb.push_back(32'hB0B0_0000 + 32'(i * 17));
    nready = 0; idx = 0; last_c = 0;
    valid[1] = 1'b1; addr[1] = 32'h0; wstrb[1] = 4'h0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready[1]) begin
        nready++;
        total++;
        if ((c - last_c) !== ((idx == 0) ? 1 : 2))
          $display("FAIL b2b_gap got %0d want %0d", c - last_c, (idx == 0) ? 1 : 2);
        else pass_cnt++;
        last_c = c;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        total++; if (rdata[1] !== exp) $display("FAIL b2b_data got %h want %h", rdata[1], exp); else pass_cnt++;
        idx++;
        if (idx < 4) addr[1] = 32'(4 * idx);
        else valid[1] = 1'b0;
      end
    end
    total++; if (nready !== 4) $display("FAIL b2b_ready_count got %0d want 4", nready); else pass_cnt++;
    last_rd[1] = 32'hB0B0_0000 + 32'(3 * 17);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic bz; logic [31:0] exp; logic saw_ready;
    xact(2, 32'h30, 32'h0, 4'hF, lat, rd, bz);
    total++; if (lat !== 4) $display("FAIL abort_pre_latency got %0d want 4", lat); else pass_cnt++;
    valid[2] = 1'b1; addr[2] = 32'h30; wdata[2] = 32'hFFFFFFFF; wstrb[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    total++; if (busy[2] !== 1'b1) $display("FAIL abort_busy got %b want 1", busy[2]); else pass_cnt++;
    @(posedge clk); #1;
    resetn = 1'b0; valid[2] = 1'b0; wstrb[2] = 4'h0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    saw_ready = 1'b0;
    @(negedge clk);
    total++; if (busy[2] !== 1'b0) $display("FAIL abort_busy_clear got %b want 0", busy[2]); else pass_cnt++;
    for (int c = 0; c < 6; c++) begin
      if (ready[2]) saw_ready = 1'b1;
      @(negedge clk);
    end
    total++; if (saw_ready !== 1'b0) $display("FAIL abort_no_ready got %b want 0", saw_ready); else pass_cnt++;
    @(posedge clk); #1;
    sb.push_back(32'h0);
    xact(2, 32'h30, 32'h0, 4'h0, lat, rd, bz);
    exp = sb.pop_front();
    total++; if (rd !== exp) $display("FAIL abort_no_write got %h want %h", rd, exp); else pass_cnt++;
    total++; if (lat !== 4) $display("FAIL abort_post_latency got %0d want 4", lat); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_alias();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
